// File: rtl/riscv_core_pkg.sv
// Shared core definitions: divider opcode encoding and its fixed latency.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_core_pkg;

    localparam int RV_XLEN     = 32;
    // Start-to-done latency of a non-special divide.
    localparam int DIV_LATENCY = RV_XLEN + 2;

    // funct3[1:0] of the RV32M divide group.
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    function automatic logic div_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU (start/done responder of EX).
// Latency: XLEN+2 cycles from start to done; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: result and done_o are held in DONE until advance_i; kill_i aborts from any state.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/kill_i/advance_i pipeline control;
//        operand_a_i/operand_b_i dividend/divisor, op_type_i funct3[1:0];
//        result_o registered quotient/remainder, done_o result valid, busy_o CALC or FIX.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [1:0]      op_type_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            busy_o
);
    import riscv_core_pkg::*;

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e           r_state, w_state_nxt;
    div_op_e          r_op, w_op_in;
    logic [XLEN-1:0]  r_rem, r_quo, r_div, r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q, r_sign_r;

    // Operand decode for the start cycle.
    logic            w_in_signed, w_in_rem, w_div_zero, w_overflow, w_special;
    logic [XLEN-1:0] w_a_abs, w_b_abs, w_special_res;

    always_comb begin
        w_op_in     = div_op_e'(op_type_i);
        w_in_signed = div_is_signed(w_op_in);
        w_in_rem    = div_is_rem(w_op_in);
        w_a_abs     = (w_in_signed && operand_a_i[XLEN-1]) ? -operand_a_i : operand_a_i;
        w_b_abs     = (w_in_signed && operand_b_i[XLEN-1]) ? -operand_b_i : operand_b_i;
        w_div_zero  = (operand_b_i == '0);
        w_overflow  = w_in_signed && (operand_a_i == MIN_NEG) && (operand_b_i == '1);
        w_special   = w_div_zero || w_overflow;
        if (w_div_zero) begin
            w_special_res = w_in_rem ? operand_a_i : '1;
        end else begin
            w_special_res = w_in_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring step. The remainder bit shifted out of the top means the
    // shifted remainder is at least 2^XLEN, which always exceeds the divisor,
    // and the low XLEN bits of the wrapped subtract are then still correct.
    logic [XLEN-1:0] w_rem_shift, w_rem_step, w_quo_step;
    logic [XLEN:0]   w_rem_sub;
    logic            w_ge;

    always_comb begin
        w_rem_shift = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
        w_rem_sub   = {1'b0, w_rem_shift} - {1'b0, r_div};
        w_ge        = r_rem[XLEN-1] || !w_rem_sub[XLEN];
        w_rem_step  = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_shift;
        w_quo_step  = {r_quo[XLEN-2:0], w_ge};
    end

    // Sign fix: quotient takes sign_q, remainder takes the dividend's sign.
    logic [XLEN-1:0] w_fix_sel, w_fix_res;
    logic            w_fix_neg;

    always_comb begin
        w_fix_sel = div_is_rem(r_op) ? r_rem : r_quo;
        w_fix_neg = div_is_signed(r_op) && (div_is_rem(r_op) ? r_sign_r : r_sign_q);
        w_fix_res = w_fix_neg ? -w_fix_sel : w_fix_sel;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i)      w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == '0)  w_state_nxt = S_FIX;
            S_FIX:                     w_state_nxt = S_DONE;
            S_DONE:  if (advance_i)    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
        if (kill_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath; a kill freezes everything, including the last result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op     <= DIV_OP_DIV;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_result <= '0;
        end else if (!kill_i) begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op     <= w_op_in;
                        r_sign_q <= operand_a_i[XLEN-1] ^ operand_b_i[XLEN-1];
                        r_sign_r <= operand_a_i[XLEN-1];
                        r_rem    <= '0;
                        r_quo    <= w_a_abs;
                        r_div    <= w_b_abs;
                        r_cnt    <= CNT_W'(XLEN - 1);
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign done_o   = (r_state == S_DONE);
    assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam int LAT_NORMAL = 34;
    localparam int N_RANDOM   = 1000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        advance_i = 1'b0;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic [1:0]  op_type_i = '0;
    logic [31:0] result_o;
    logic        done_o;
    logic        busy_o;

    div_unit #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .kill_i      (kill_i),
        .advance_i   (advance_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .op_type_i   (op_type_i),
        .result_o    (result_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int tests = 0;
    int fails = 0;
    bit abort = 1'b0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics with plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0] == 1'b0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT_NORMAL;
    endfunction

    // Monitor: pops the scoreboard whenever done_o rises, checks hold while in DONE.
    logic        done_prev = 1'b0;
    logic [31:0] held = '0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            done_prev = 1'b0;
        end else begin
            if (done_o && !done_prev) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got done with result %h, expected no done", result_o);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result_o, e.res);
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                end
                held = result_o;
            end else if (done_o) begin
                check("result_hold", result_o, held);
            end
            done_prev = done_o;
        end
    end

    // Issue one divide, keep start high until done, stall 'hold' cycles with
    // toggling operands, then advance (mode 0) or kill (mode 1) from DONE.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold, input int mode);
        exp_t e;
        int   n;
        @(negedge clk_i);
        start_i     = 1'b1;
        op_type_i   = op;
        operand_a_i = a;
        operand_b_i = b;
        e.res = exp;
        e.lat = exp_latency(op, a, b);
        e.t0  = cyc;
        sb_q.push_back(e);
        @(negedge clk_i);
        n = 1;
        while (!done_o && n < 60) begin
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            @(negedge clk_i);
            n++;
        end
        if (!done_o) begin
            check("done_timeout", {31'b0, done_o}, 32'h1);
            void'(sb_q.pop_back());
            abort = 1'b1;
            start_i = 1'b0;
            return;
        end
        repeat (hold) begin
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            op_type_i   = 2'($urandom);
            @(negedge clk_i);
        end
        if (hold > 0) check("done_held", {31'b0, done_o}, 32'h1);
        if (mode == 0) begin
            advance_i = 1'b1;
            @(negedge clk_i);
            advance_i = 1'b0;
            check("idle_after_adv", {30'b0, done_o, busy_o}, 32'h0);
        end else begin
            kill_i = 1'b1;
            @(negedge clk_i);
            kill_i = 1'b0;
            check("kill_done_drop", {30'b0, done_o, busy_o}, 32'h0);
            check("kill_keeps_res", result_o, exp);
        end
        start_i = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;

        #1;
        check("rst_result", result_o, 32'h0);
        check("rst_flags", {30'b0, done_o, busy_o}, 32'h0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed cases; DIVU 100/7 also stalls 10 cycles in DONE.
        do_op(2'b01, 32'd100, 32'd7, 32'd14, 10, 0);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 0, 0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 0);
        do_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
        do_op(2'b11, 32'd5, 32'd0, 32'd5, 0, 0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 0, 0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0, 0);
        // Kill while in DONE: done drops, result retained.
        do_op(2'b01, 32'd1000, 32'd3, 32'd333, 2, 1);

        // Start together with kill in IDLE is ignored.
        @(negedge clk_i);
        start_i = 1'b1; kill_i = 1'b1; op_type_i = 2'b01;
        operand_a_i = 32'd50; operand_b_i = 32'd5;
        @(negedge clk_i);
        start_i = 1'b0; kill_i = 1'b0;
        check("kill_idle_start", {30'b0, done_o, busy_o}, 32'h0);

        // Kill at CALC cycle 15, restart two cycles later.
        @(negedge clk_i);
        start_i = 1'b1; op_type_i = 2'b01;
        operand_a_i = 32'd12345; operand_b_i = 32'd11;
        e.res = 32'd1122; e.lat = LAT_NORMAL; e.t0 = cyc;
        sb_q.push_back(e);
        repeat (15) @(negedge clk_i);
        check("busy_calc", {31'b0, busy_o}, 32'h1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0; start_i = 1'b0;
        void'(sb_q.pop_back());
        check("kill_calc_idle", {30'b0, done_o, busy_o}, 32'h0);
        @(negedge clk_i);
        check("kill_calc_stay", {30'b0, done_o, busy_o}, 32'h0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 0, 0);

        // Asynchronous reset mid-CALC clears all outputs immediately.
        @(negedge clk_i);
        start_i = 1'b1; op_type_i = 2'b00;
        operand_a_i = 32'd99; operand_b_i = 32'd4;
        e.res = 32'd24; e.lat = LAT_NORMAL; e.t0 = cyc;
        sb_q.push_back(e);
        repeat (10) @(negedge clk_i);
        check("busy_pre_rst", {31'b0, busy_o}, 32'h1);
        check("res_pre_rst", result_o, 32'h0FFF_FFFF);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_result", result_o, 32'h0);
        check("rst_mid_flags", {30'b0, done_o, busy_o}, 32'h0);
        void'(sb_q.pop_back());
        start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < N_RANDOM && !abort; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 16);
                3: b = b | 32'h8000_0000;
                4: a = $urandom_range(0, 100);
                default: ;
            endcase
            do_op(op, a, b, ref_model(op, a, b), $urandom_range(0, 2), 0);
        end

        repeat (3) @(negedge clk_i);
        if (sb_q.size() != 0) begin
            check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
